// File: rtl/pe_link_rr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one outbound link among NUM_REQ requesters.
// Latency: grant 1 cycle after request, first link beat 2 cycles after request; 1 beat/cycle while locked.
// Backpressure: req_ready only to the locked requester when ap_start and the output slot is free; optional stall abort via PE_LINK_ARB_TIMEOUT_EN.
module pe_link_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int DATA_WIDTH = 130
`ifdef PE_LINK_ARB_TIMEOUT_EN
    ,
    parameter int STALL_LIMIT = 255
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ap_start,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          link_valid,
    output logic                          link_last,
    output logic [DATA_WIDTH-1:0]         link_data,
    input  logic                          link_ready,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic                          busy
`ifdef PE_LINK_ARB_TIMEOUT_EN
    ,
    output logic                          timeout_err
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam int W1 = ID_WIDTH + 1;

    state_t                  state_q, state_d;
    logic [ID_WIDTH-1:0]     grant_q, grant_d;
    logic                    vld_q, vld_d;
    logic                    last_q, last_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;

    logic [W1-1:0]           base;
    logic [W1-1:0]           cand;
    logic [NUM_REQ-1:0]      rot;
    logic                    win_vld;
    logic [ID_WIDTH-1:0]     win_id;

    logic [NUM_REQ-1:0]      gnt_oh;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_last;
    logic                    sel_valid;
    logic                    slot_free;
    logic                    xfer;

`ifdef PE_LINK_ARB_TIMEOUT_EN
    localparam int STALL_W = (STALL_LIMIT < 256) ? 8 : 16;
    logic [STALL_W-1:0]      stall_q, stall_d;
    logic                    err_q, err_d;
`endif

    // Rotate the request vector so bit 0 is the requester just after the pointer.
    always_comb begin
        base    = {1'b0, grant_q} + W1'(1);
        rot     = NUM_REQ'({req_valid, req_valid} >> base);
        win_vld = |req_valid;
        cand    = '0;
        win_id  = grant_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                cand   = base + W1'(k);
                win_id = (cand >= W1'(NUM_REQ)) ? ID_WIDTH'(cand - W1'(NUM_REQ))
                                                : ID_WIDTH'(cand);
            end
        end
    end

    always_comb begin
        gnt_oh    = '0;
        sel_data  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == ID_WIDTH'(i)) begin
                gnt_oh[i] = 1'b1;
                sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_last  = req_last[i];
                sel_valid = req_valid[i];
            end
        end
    end

    assign slot_free = !vld_q || link_ready;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        req_ready = '0;
        xfer      = 1'b0;
`ifdef PE_LINK_ARB_TIMEOUT_EN
        stall_d   = '0;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (ap_start && win_vld) begin
                    state_d = LOCK;
                    grant_d = win_id;
                end
            end
            LOCK: begin
                req_ready = gnt_oh & {NUM_REQ{ap_start && slot_free}};
                xfer      = sel_valid && ap_start && slot_free;
                if (xfer && sel_last) begin
                    state_d = IDLE;
                end
`ifdef PE_LINK_ARB_TIMEOUT_EN
                // Pointer stays on the stalled requester so the next search starts after it.
                if (!xfer) begin
                    stall_d = stall_q;
                    if (ap_start) begin
                        stall_d = stall_q + STALL_W'(1);
                        if (stall_d == STALL_W'(STALL_LIMIT)) begin
                            state_d = IDLE;
                            err_d   = 1'b1;
                            stall_d = '0;
                        end
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register drains on link_ready regardless of ap_start.
    always_comb begin
        vld_d  = vld_q;
        last_d = last_q;
        data_d = data_q;
        if (xfer) begin
            vld_d  = 1'b1;
            last_d = sel_last;
            data_d = sel_data;
        end else if (vld_q && link_ready) begin
            vld_d  = 1'b0;
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= ID_WIDTH'(NUM_REQ - 1);
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
`ifdef PE_LINK_ARB_TIMEOUT_EN
            stall_q <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            data_q  <= data_d;
`ifdef PE_LINK_ARB_TIMEOUT_EN
            stall_q <= stall_d;
            err_q   <= err_d;
`endif
        end
    end

    assign link_valid = vld_q;
    assign link_last  = last_q;
    assign link_data  = data_q;
    assign grant_id   = grant_q;
    assign busy       = (state_q == LOCK);
`ifdef PE_LINK_ARB_TIMEOUT_EN
    assign timeout_err = err_q;
`endif

endmodule
